// File: rtl/debug_pattern_generator.sv
// Colour-bar test-pattern source for an asynchronous FIFO write port.
// Produces RGB565 frames in raster order: ten vertical bars, identical rows,
// with a start-of-frame flag on bit 16 of the first pixel of every frame.
// Back-pressure from queue_full stalls the pattern without losing a pixel.
module debug_pattern_generator #(
    parameter int   FRAME_WIDTH      = 640,
    parameter int   FRAME_HEIGHT     = 480,
    parameter logic SEND_EXTRA_DATA  = 1'b0,
    parameter int   FRAME_GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en
);

    localparam int COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int GAP_W = (FRAME_GAP_CYCLES > 1) ? $clog2(FRAME_GAP_CYCLES) : 1;
    localparam int BAR_W = FRAME_WIDTH / 10;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((FRAME_GAP_CYCLES > 0) ? (FRAME_GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_START,
        ST_SEND,
        ST_EXTRA,
        ST_GAP
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bar;
    logic [15:0]      colour;

    // Bar index: the highest bar whose left edge the column has reached, so
    // bar 9 absorbs any remainder columns when the width is not a multiple of 10.
    // NOTE: every variable written in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        bar = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (int'(col) >= i * BAR_W) begin
                bar = 4'(i);
            end
        end
    end

    // RGB565 colour lookup for the ten bars.
    always_comb begin
        case (bar)
            4'd0:    colour = 16'hFFFF; // white
            4'd1:    colour = 16'hFFE0; // yellow
            4'd2:    colour = 16'h07FF; // cyan
            4'd3:    colour = 16'h07E0; // green
            4'd4:    colour = 16'hF81F; // magenta
            4'd5:    colour = 16'hF800; // red
            4'd6:    colour = 16'h001F; // blue
            4'd7:    colour = 16'h0000; // black
            4'd8:    colour = 16'h8410; // grey
            default: colour = 16'hFD20; // orange
        endcase
    end

    // Output word: a pixel in SEND, all zeros otherwise (including the extra word).
    always_comb begin
        queue_data = 17'h0_0000;
        if (state == ST_SEND) begin
            queue_data = {(col == '0) && (row == '0), colour};
        end
    end

    assign queue_wr_en = ((state == ST_SEND) || (state == ST_EXTRA)) && !queue_full;

    // Frame sequencer: counters and state move only on a written word, or on
    // gap cycles, so a full FIFO simply freezes everything in place.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_START;
            col     <= '0;
            row     <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_START: begin
                    state <= ST_SEND;
                end

                ST_SEND: begin
                    if (queue_wr_en) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row <= '0;
                                if (SEND_EXTRA_DATA) begin
                                    state <= ST_EXTRA;
                                end else if (FRAME_GAP_CYCLES > 0) begin
                                    state <= ST_GAP;
                                end else begin
                                    state <= ST_SEND;
                                end
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end

                ST_EXTRA: begin
                    if (queue_wr_en) begin
                        state <= (FRAME_GAP_CYCLES > 0) ? ST_GAP : ST_SEND;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_pattern_generator.sv
// Scoreboard bench for debug_pattern_generator.
// Four instances cover: 640x20 plain (free-running, random stalls, mid-row
// reset), 645x1 remainder bar, 16x2 with extra word, 16x1 with a 5-cycle gap.
// The stimulus side pushes expected words; a negedge monitor pops and compares
// every written word, and checks that stalled outputs hold the pending word.
module tb_debug_pattern_generator;

    typedef struct {
        logic [16:0] d;
        int          gap;   // expected idle cycles before this write, -1 = don't care
    } exp_t;

    logic             clk = 1'b0;
    logic             rst0_n = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       full = 4'hF;
    logic [3:0]       wr;
    logic [3:0][16:0] dat;

    exp_t exp_q[4][$];
    int   idle[4];
    int   nword[4];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    debug_pattern_generator #(.FRAME_WIDTH(640), .FRAME_HEIGHT(20)) u_dut0 (
        .clk(clk), .reset_n(rst0_n), .queue_full(full[0]),
        .queue_data(dat[0]), .queue_wr_en(wr[0])
    );

    debug_pattern_generator #(.FRAME_WIDTH(645), .FRAME_HEIGHT(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .queue_full(full[1]),
        .queue_data(dat[1]), .queue_wr_en(wr[1])
    );

    debug_pattern_generator #(.FRAME_WIDTH(16), .FRAME_HEIGHT(2),
                              .SEND_EXTRA_DATA(1'b1)) u_dut2 (
        .clk(clk), .reset_n(rst_n), .queue_full(full[2]),
        .queue_data(dat[2]), .queue_wr_en(wr[2])
    );

    debug_pattern_generator #(.FRAME_WIDTH(16), .FRAME_HEIGHT(1),
                              .FRAME_GAP_CYCLES(5)) u_dut3 (
        .clk(clk), .reset_n(rst_n), .queue_full(full[3]),
        .queue_data(dat[3]), .queue_wr_en(wr[3])
    );

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference colour table, straight from the bar list.
    function automatic logic [15:0] bar_colour(input int col, input int w);
        int b;
        b = col / (w / 10);
        if (b > 9) b = 9;
        case (b)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            7:       return 16'h0000;
            8:       return 16'h8410;
            default: return 16'hFD20;
        endcase
    endfunction

    task automatic push(input int i, input logic [16:0] d, input int gap);
        exp_t e;
        e.d   = d;
        e.gap = gap;
        exp_q[i].push_back(e);
    endtask

    // Push raster indices first..last of a w-wide frame.
    task automatic push_range(input int i, input int w, input int first, input int last,
                              input int gap_first, input int gap_rest);
        for (int k = first; k <= last; k++) begin
            push(i, {(k == 0), bar_colour(k % w, w)}, (k == first) ? gap_first : gap_rest);
        end
    endtask

    // Release back-pressure on instance i until its expected queue drains,
    // then stall it again right after the last expected write.
    task automatic run(input int i, input bit rnd, input int limit);
        int c;
        @(posedge clk); #1;
        for (c = 0; c < limit; c++) begin
            if (exp_q[i].size() == 0) break;
            full[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        full[i] = 1'b1;
        if (c >= limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_inst%0d: %0d words still pending after %0d cycles",
                     i, exp_q[i].size(), limit);
            exp_q[i].delete();
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (wr[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("unexpected_write_inst%0d", i), wr[i], 1'b0);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("word_inst%0d_n%0d", i, nword[i]), dat[i], e.d);
                    if (e.gap >= 0) begin
                        check_int($sformatf("idle_inst%0d_n%0d", i, nword[i]), idle[i], e.gap);
                    end
                end
                nword[i]++;
                idle[i] = 0;
            end else begin
                idle[i]++;
                if (full[i] && exp_q[i].size() != 0) begin
                    check($sformatf("stall_hold_inst%0d", i), dat[i], exp_q[i][0].d);
                end
            end
            if (full[i] && exp_q[i].size() != 0) begin
                check($sformatf("no_wr_when_full_inst%0d", i), wr[i], 1'b0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            idle[i]  = 0;
            nword[i] = 0;
        end

        // Reset state on every instance.
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_data_inst%0d", i), dat[i], 17'h0);
            check($sformatf("reset_wr_inst%0d", i), wr[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst0_n = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 640x20 back-to-back: full frame, then the next frame's SOF pixel.
        push_range(0, 640, 0, 12799, -1, 0);
        push(0, 17'h1_FFFF, 0);
        run(0, 1'b0, 20000);

        // Same frame under ~50% random back-pressure, from a fresh reset.
        rst0_n = 1'b0;
        @(posedge clk); #2;
        rst0_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_range(0, 640, 0, 12799, -1, -1);
        push(0, 17'h1_FFFF, -1);
        run(0, 1'b1, 40000);

        // Advance to col 300, row 7, then reset mid-row.
        push_range(0, 640, 1, 7 * 640 + 299, -1, -1);
        run(0, 1'b0, 10000);
        @(posedge clk); #1;
        full[0] = 1'b0;
        #2;
        check("pre_reset_wr", wr[0], 1'b1);
        check("pre_reset_data_col300", dat[0], 17'h0_F81F);
        rst0_n = 1'b0;
        #1;
        check("mid_reset_data", dat[0], 17'h0);
        check("mid_reset_wr", wr[0], 1'b0);
        full[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst0_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_range(0, 640, 0, 9, -1, 0);
        run(0, 1'b0, 100);

        // 645-wide: bar 9 covers columns 576..644.
        push_range(1, 645, 0, 644, -1, 0);
        push(1, 17'h1_FFFF, 0);
        run(1, 1'b0, 2000);

        // 16x2 with extra word: 32 pixels, 17'h0, then SOF of the next frame.
        push_range(2, 16, 0, 31, -1, 0);
        push(2, 17'h0_0000, 0);
        push(2, 17'h1_FFFF, 0);
        push_range(2, 16, 1, 15, 0, 0);
        run(2, 1'b0, 200);

        // 16x1 with a 5-cycle gap between frames.
        push_range(3, 16, 0, 15, -1, 0);
        push(3, 17'h1_FFFF, 5);
        push_range(3, 16, 1, 15, 0, 0);
        push(3, 17'h1_FFFF, 5);
        run(3, 1'b0, 200);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_pattern_generator.md
Name: debug_pattern_generator

Overview:
- Free-running colour-bar test-pattern source that feeds RGB565 pixels, frame by frame, into a 17-bit-wide write port of an asynchronous FIFO.
- Sits in place of the camera capture path so the video controller and frame buffer can be exercised with a known image.
- Respects FIFO back-pressure (queue_full) and never drops or duplicates a pixel.

Parameters:
- FRAME_WIDTH, 640, pixels per row (must be >= 10).
- FRAME_HEIGHT, 480, rows per frame (>= 1).
- SEND_EXTRA_DATA, 1'b0: 1 = append one extra dummy word after the last pixel of every frame.
- FRAME_GAP_CYCLES, 0: idle clk cycles inserted between frames (0 = back-to-back).

Ports:
- clk  in  1  pattern/FIFO write clock.
- reset_n  in  1  asynchronous active-low reset.
- queue_full  in  1  FIFO full flag, synchronous to clk.
- queue_data  out  17  bit16 = start-of-frame marker, [15:0] = RGB565 pixel.
- queue_wr_en  out  1  FIFO write strobe.

Behaviour:
- Reset: reset is reset_n, asynchronous, active-low; clock is clk. During reset, col=0, row=0, state=START, queue_data=0, queue_wr_en=0.
- Bar width BW = FRAME_WIDTH/10 (integer division).
- Bar index = min(col/BW, 9); the last bar absorbs the remainder.
- Colours, bars 0..9: FFFF white, FFE0 yellow, 07FF cyan, 07E0 green, F81F magenta, F800 red, 001F blue, 0000 black, 8410 grey, FD20 orange.
- Every row is identical; the pattern is independent of row.
- States:
  - START: one cycle after reset, then SEND.
  - SEND: emit pixels.
  - EXTRA: only when SEND_EXTRA_DATA=1.
  - GAP: only when FRAME_GAP_CYCLES>0; counts the gap, then SEND.
- queue_data is driven combinationally from the current (col,row) and state.
  - bit16 = 1 only for pixel (col=0,row=0).
  - In EXTRA the word is 17'h0_0000.
- queue_wr_en = (state==SEND or EXTRA) && !queue_full, combinational. A word counts as written exactly in a cycle where queue_wr_en=1 at the rising clk edge.
- Counters advance only on a written word:
  - col increments.
  - At col==FRAME_WIDTH-1, col wraps to 0 and row increments.
  - At the last pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1), row wraps to 0 and the next state is EXTRA, else GAP, else SEND.
- EXTRA: after its one word is written, go to GAP (if FRAME_GAP_CYCLES>0) else SEND.
- GAP: queue_wr_en=0 for exactly FRAME_GAP_CYCLES cycles, then SEND.
- queue_full high: queue_wr_en low, counters and data held stable; resume on the first cycle queue_full is low.
- Frames repeat forever. Each frame delivers exactly FRAME_WIDTH*FRAME_HEIGHT pixels (plus one extra word if enabled), in raster order.
- Reset mid-frame: immediate return to START with counters at 0. The next frame restarts at (0,0) with bit16=1.
- Counter widths: ceil(log2) of FRAME_WIDTH and FRAME_HEIGHT, minimum 1 bit each; no overflow beyond the wrap points.

Test Plan:
- 640x20, queue_full tied 0, SEND_EXTRA_DATA=0 -> 12800 writes, then the next write has bit16=1.
  - Columns 0..63 = FFFF, 64..127 = FFE0, …, 576..639 = FD20; 20 rows counted.
- Random queue_full toggling (~50%) on 640x20 -> same 12800-word sequence as above.
  - No write while full; data held stable across stall cycles.
- FRAME_WIDTH=645 -> bar 9 spans columns 576..644 (69 pixels, FD20).
- SEND_EXTRA_DATA=1, 16x2 -> 32 pixel words then one 17'h00000 word, then pixel (0,0) with bit16=1.
- FRAME_GAP_CYCLES=5 -> exactly 5 cycles with queue_wr_en=0 between the last pixel and the next frame's first word.
- Assert reset_n low mid-row (e.g. col 300, row 7) -> outputs 0 immediately.
  - After release, first written word = 1_FFFF (SOF + white).
